// File: rtl/counter_mode_pkg.sv
// Shared opcodes, counting modes and FSM state encoding for counter_mode_ctrl.
package counter_mode_pkg;

  localparam logic [1:0] OP_STOP  = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] MODE_UP      = 2'b00;
  localparam logic [1:0] MODE_DOWN    = 2'b01;
  localparam logic [1:0] MODE_MOD     = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/counter_mode_ctrl_step.sv
// counter_step: combinational next-value logic for one qualified tick.
// DOWN mode exists only when COUNTER_MODE_CTRL_DOWN_EN is defined.
module counter_step
  import counter_mode_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
  output logic [WIDTH-1:0] q_nxt_o,
  output logic             wrap_o,
  output logic             hit_o
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL1 = {WIDTH{1'b1}};

  // Next counter value and wrap/hit flags for the latched mode.
  always_comb begin
    q_nxt_o = q_i;
    wrap_o  = 1'b0;
    hit_o   = 1'b0;
    case (mode_i)
      MODE_UP: begin
        q_nxt_o = q_i + ONE;
        wrap_o  = (q_i == ALL1);
      end
`ifdef COUNTER_MODE_CTRL_DOWN_EN
      MODE_DOWN: begin
        q_nxt_o = q_i - ONE;
        wrap_o  = (q_i == {WIDTH{1'b0}});
      end
`endif
      MODE_MOD: begin
        // q above hi (left by a LOAD) restarts at lo just like q == hi
        if (q_i >= hi_i) begin
          q_nxt_o = lo_i;
          wrap_o  = 1'b1;
        end else begin
          q_nxt_o = q_i + ONE;
        end
      end
      MODE_ONESHOT: begin
        if (q_i >= hi_i) begin
          q_nxt_o = q_i;
          hit_o   = 1'b1;
        end else begin
          q_nxt_o = q_i + ONE;
        end
      end
      default: q_nxt_o = q_i;
    endcase
  end

endmodule

// File: rtl/counter_mode_ctrl.sv
// Command-driven counter controller: handshake, mode/bounds latch, RUN/IDLE/DONE FSM.
// Optional DOWN mode is enabled by defining COUNTER_MODE_CTRL_DOWN_EN.
module counter_mode_ctrl
  import counter_mode_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_lo,
  input  logic [WIDTH-1:0] cmd_hi,
  input  logic             tick,
  output logic [WIDTH-1:0] q,
  output logic             running,
  output logic             done,
  output logic             wrap,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, lo_q, lo_d, hi_q, hi_d;
  logic [1:0]       mode_q, mode_d;
  logic             ready_q, ready_d, done_q, done_d, wrap_q, wrap_d, err_q, err_d;

  logic             accept_s, bounds_bad_s, mode_bad_s;
  logic [WIDTH-1:0] step_q_s;
  logic             step_wrap_s, step_hit_s;

  assign accept_s     = cmd_valid & ready_q;
  assign bounds_bad_s = ((cmd_mode == MODE_MOD) | (cmd_mode == MODE_ONESHOT)) & (cmd_lo > cmd_hi);
`ifdef COUNTER_MODE_CTRL_DOWN_EN
  assign mode_bad_s   = 1'b0;
`else
  assign mode_bad_s   = (cmd_mode == MODE_DOWN);
`endif

  counter_step #(.WIDTH(WIDTH)) u_step (
    .q_i     (q_q),
    .mode_i  (mode_q),
    .lo_i    (lo_q),
    .hi_i    (hi_q),
    .q_nxt_o (step_q_s),
    .wrap_o  (step_wrap_s),
    .hit_o   (step_hit_s)
  );

  // Next-state: an accepted command always beats a same-cycle tick.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    mode_d  = mode_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    ready_d = ~accept_s;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (accept_s) begin
      case (cmd_op)
        OP_STOP: begin
          if (state_q == ST_RUN) state_d = ST_IDLE;
          else                   state_d = state_q;
        end
        OP_START: begin
          if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
          end else if (state_q == ST_DONE) begin
            state_d = ST_RUN;
            q_d     = lo_q;
          end else begin
            state_d = state_q;
          end
        end
        OP_LOAD: begin
          if (bounds_bad_s | mode_bad_s) begin
            err_d = 1'b1;
          end else begin
            q_d    = cmd_lo;
            mode_d = cmd_mode;
            lo_d   = cmd_lo;
            hi_d   = cmd_hi;
          end
        end
        OP_CLEAR: begin
          state_d = ST_IDLE;
          q_d     = lo_q;
        end
        default: state_d = state_q;
      endcase
    end else if (tick && (state_q == ST_RUN)) begin
      q_d    = step_q_s;
      wrap_d = step_wrap_s;
      if (step_hit_s) begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end else begin
        state_d = state_q;
      end
    end else begin
      q_d = q_q;
    end
  end

  // State, configuration and output pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      q_q     <= {WIDTH{1'b0}};
      mode_q  <= MODE_UP;
      lo_q    <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b1}};
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      mode_q  <= mode_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign q         = q_q;
  assign running   = (state_q == ST_RUN);
  assign done      = done_q;
  assign wrap      = wrap_q;
  assign err       = err_q;

endmodule

// File: doc/counter_mode_ctrl.md
# counter_mode_ctrl

Controller that sequences and configures a WIDTH-bit counter register according to a command stream. It accepts start/stop/load/clear commands over a valid/ready handshake and latches a counting mode (up, down, modulo range, one-shot) with range bounds. It then advances the counter on qualified `tick` strobes. It sits between the lab's command/control logic (switches, debounced buttons, higher FSMs) and display or compare logic that consumes `q`.

## Interface
- `WIDTH`, default 4: counter and bound width in bits.
- `clk`  in  1: single system clock, rising edge.
- `reset_n`  in  1: reset is asynchronous and active-low. One clock domain only.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: controller can accept a command this cycle.
- `cmd_op`  in  2: command opcode. 00 STOP, 01 START, 10 LOAD, 11 CLEAR.
- `cmd_mode`  in  2: mode, used by LOAD only. 00 UP, 01 DOWN, 10 MOD, 11 ONESHOT.
- `cmd_lo`  in  WIDTH: lower bound, used by LOAD only.
- `cmd_hi`  in  WIDTH: upper bound, used by LOAD only.
- `tick`  in  1: count-enable strobe.
- `q`  out  WIDTH: counter value.
- `running`  out  1: FSM is in the RUN state.
- `done`  out  1: one-cycle pulse when ONESHOT reaches `hi`.
- `wrap`  out  1: one-cycle pulse on any wrap-around.
- `err`  out  1: one-cycle pulse when a LOAD is rejected.

## Operation
- Command accept: a command is accepted when `cmd_valid & cmd_ready` is high on a rising edge.
- `cmd_ready` drops for exactly the cycle after each accepted command, then returns high. Back-to-back commands therefore cost 2 cycles each.
- Latched configuration: `mode`, `lo`, `hi`. Reset values: UP, 0, all-ones.
- FSM states and transitions:
  - IDLE: START → RUN.
  - RUN: STOP → IDLE; ONESHOT reaching `hi` → DONE.
  - DONE: START → RUN and sets `q <= lo`.
  - CLEAR from any state → IDLE with `q <= lo`.
- LOAD:
  - Sets `q <= cmd_lo` and latches the mode and both bounds. The FSM state is unchanged.
  - If mode is MOD or ONESHOT and `cmd_lo > cmd_hi`: reject the LOAD, pulse `err`, and leave the configuration and `q` untouched.
- Counting happens only in RUN with `tick=1`:
  - UP: `q+1`, modulo 2^WIDTH. Pulse `wrap` on all-ones → 0.
  - DOWN: `q-1`. Pulse `wrap` on 0 → all-ones.
  - MOD: if `q >= hi`, load `lo` and pulse `wrap`; otherwise `q+1`. This covers an out-of-range `q` left behind by an earlier LOAD.
  - ONESHOT: if `q == hi`, hold `q`, pulse `done`, go to DONE. If `q > hi`, treat it the same as `q == hi`. Otherwise `q+1`.
- Simultaneous events: an accepted command and a `tick` in the same cycle → the command wins and the tick is dropped (not queued).
- `tick` in IDLE or DONE is ignored.
- `running` equals (state == RUN).

## Timing
- Reset (async assert, sync release): `q=0`, `running=0`, `done=0`, `wrap=0`, `err=0`, `cmd_ready=1`, state IDLE.
- Reset mid-count clears immediately. No command is retained.
- Latency: a command or tick sampled at edge k is visible on `q`/`running` after edge k (1 cycle).
- `done`, `wrap` and `err` are registered. Each is high for the single cycle that coincides with the `q` update that caused it.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `COUNTER_MODE_CTRL_DOWN_EN`.
- Defined: DOWN mode is implemented as described.
- Undefined: DOWN-mode logic is removed. A LOAD with mode 01 is rejected with an `err` pulse; configuration and `q` are unchanged.

## Structure
- Package `counter_mode_pkg` holds:
  - opcode constants: OP_STOP, OP_START, OP_LOAD, OP_CLEAR;
  - mode constants: MODE_UP, MODE_DOWN, MODE_MOD, MODE_ONESHOT;
  - FSM state encoding: ST_IDLE, ST_RUN, ST_DONE.
- Sub-module `counter_step`: purely combinational next-value logic. Inputs: `q`, `mode`, `lo`, `hi`. Outputs: next `q`, wrap flag, hit-hi flag.
- The top level holds the FSM, the handshake logic and the registers.

## Test plan
- Reset with `q` mid-count at 7 → `q=0`, `cmd_ready=1`, all pulses low, `running=0` immediately.
- LOAD UP lo=14, START, 3 ticks → `q` goes 15, 0, 1; `wrap` high on the 0 cycle only.
- LOAD MOD lo=1 hi=11, START, ticks → `q` goes 1…11, then 1; `wrap` pulses on the 11 → 1 step. Matching 1-based-wrap behaviour is required.
- LOAD ONESHOT lo=2 hi=4, START, 5 ticks → `q` goes 3, 4 and holds at 4; `done` pulses once; `running=0`. A later START → `q=2`, RUN.
- LOAD MOD lo=9 hi=3 → `err` pulse; previous configuration and `q` unchanged. Separately, a tick coincident with an accepted STOP → `q` unchanged and IDLE.
- DOWN at `q=0` with the macro defined → `q=15` with a `wrap` pulse. Without the macro → LOAD with mode 01 gives an `err` pulse.
